// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the mm:ss BCD countdown timer.
//   - DigitW             : width of one BCD digit
//   - BcdMax             : largest legal BCD digit value
//   - SecTensWrapDefault : value sec_tens reloads to on borrow (mm:ss rollover)
//   - bcd_t              : one BCD digit
//   - is_bcd()           : true when a keypad code is a legal decimal digit
package countdown_timer_pkg;

    localparam int unsigned DigitW             = 4;
    localparam int unsigned SecTensWrapDefault = 5;

    typedef logic [DigitW-1:0] bcd_t;

    localparam bcd_t BcdMax = 4'd9;

    function automatic logic is_bcd(input bcd_t d);
        return d <= BcdMax;
    endfunction

endpackage

// File: rtl/countdown_timer_bcd_down_digit.sv
// One BCD digit of the countdown chain.
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset, clears the digit to 0
//   load_i      parallel load of load_val_i (has priority over dec_i)
//   load_val_i  value to load
//   dec_i       decrement by one; a 0 reloads to Wrap
//   q_o         current digit value
//   borrow_o    dec_i while the digit is 0, feeds the next digit's dec_i
module countdown_timer_bcd_down_digit
    import countdown_timer_pkg::*;
#(
    parameter int unsigned Wrap = 9
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  bcd_t load_val_i,
    input  logic dec_i,
    output bcd_t q_o,
    output logic borrow_o
);

    bcd_t q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_val_i;
        end else if (dec_i) begin
            q_d = (q_q == '0) ? bcd_t'(Wrap) : q_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o      = q_q;
    assign borrow_o = dec_i & (q_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// mm:ss BCD countdown register fed by the keypad coder and a 1 Hz pulse train.
// Idle (enn_i=1): each valid keypad digit shifts in from the right.
// Counting (enn_i=0): decrements once per 1 Hz tick until 00:00.
// Ports:
//   clk_i       system clock, all state on the rising edge
//   rst_ni      asynchronous active-low reset
//   d_i         BCD digit from the keyboard coder, valid while loadn_i=0
//   loadn_i     active-low key-held strobe (asynchronous)
//   pgt_1hz_i   1 Hz pulse train, rising edge = one tick (asynchronous)
//   enn_i       active-low count enable from the control FSM
//   sec_ones_o  BCD seconds units     sec_tens_o  BCD seconds tens
//   min_ones_o  BCD minutes units     min_tens_o  BCD minutes tens
//   zero_o      all four digits are 0
//   done_o      one-clock pulse after the tick that reaches 00:00
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned SyncStages  = 2,
    parameter int unsigned SecTensWrap = SecTensWrapDefault
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  bcd_t d_i,
    input  logic loadn_i,
    input  logic pgt_1hz_i,
    input  logic enn_i,
    output bcd_t sec_ones_o,
    output bcd_t sec_tens_o,
    output bcd_t min_ones_o,
    output bcd_t min_tens_o,
    output logic zero_o,
    output logic done_o
);

    logic [SyncStages-1:0] loadn_sync_q, pgt_sync_q;
    logic                  loadn_prev_q, pgt_prev_q;
    logic                  done_q, done_d;
    logic                  loadn_s, pgt_s;
    logic                  key_evt, tick;
    logic                  shift_en, dec_en;
    logic                  borrow_so, borrow_st, borrow_mo;
    logic                  min_tens_borrow_unused;

    // Synchronisers plus one edge-detect flop each; everything resets to 0, so the idle-high
    // loadn_i produces a rising (ignored) edge after reset rather than a key event.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            loadn_sync_q <= '0;
            pgt_sync_q   <= '0;
            loadn_prev_q <= 1'b0;
            pgt_prev_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            loadn_sync_q <= {loadn_sync_q[SyncStages-2:0], loadn_i};
            pgt_sync_q   <= {pgt_sync_q[SyncStages-2:0], pgt_1hz_i};
            loadn_prev_q <= loadn_s;
            pgt_prev_q   <= pgt_s;
            done_q       <= done_d;
        end
    end

    assign loadn_s = loadn_sync_q[SyncStages-1];
    assign pgt_s   = pgt_sync_q[SyncStages-1];
    assign key_evt = loadn_prev_q & ~loadn_s;
    assign tick    = pgt_s & ~pgt_prev_q;

    assign zero_o   = (sec_ones_o == '0) && (sec_tens_o == '0) &&
                      (min_ones_o == '0) && (min_tens_o == '0);
    assign shift_en = enn_i & key_evt & is_bcd(d_i);
    assign dec_en   = ~enn_i & tick & ~zero_o;

    // Only 00:01-equivalent (units 1, rest 0) can reach 00:00 on one decrement.
    always_comb begin
        done_d = dec_en && (sec_ones_o == 4'd1) && (sec_tens_o == '0) &&
                 (min_ones_o == '0) && (min_tens_o == '0);
    end

    assign done_o = done_q;

    countdown_timer_bcd_down_digit #(.Wrap(BcdMax)) u_sec_ones (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (shift_en),
        .load_val_i (d_i),
        .dec_i      (dec_en),
        .q_o        (sec_ones_o),
        .borrow_o   (borrow_so)
    );

    countdown_timer_bcd_down_digit #(.Wrap(SecTensWrap)) u_sec_tens (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (shift_en),
        .load_val_i (sec_ones_o),
        .dec_i      (borrow_so),
        .q_o        (sec_tens_o),
        .borrow_o   (borrow_st)
    );

    countdown_timer_bcd_down_digit #(.Wrap(BcdMax)) u_min_ones (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (shift_en),
        .load_val_i (sec_tens_o),
        .dec_i      (borrow_st),
        .q_o        (min_ones_o),
        .borrow_o   (borrow_mo)
    );

    // Never borrows: decrement is blocked at 00:00.
    countdown_timer_bcd_down_digit #(.Wrap(BcdMax)) u_min_tens (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (shift_en),
        .load_val_i (min_ones_o),
        .dec_i      (borrow_mo),
        .q_o        (min_tens_o),
        .borrow_o   (min_tens_borrow_unused)
    );

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    localparam int unsigned SyncStages  = 2;
    localparam int unsigned SecTensWrap = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] d;
    logic       loadn;
    logic       pgt;
    logic       enn;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       zero, done;

    int n_cmp    = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int model_n  = 0;  // displayed mm:ss read as a 4-digit decimal number

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    countdown_timer #(
        .SyncStages  (SyncStages),
        .SecTensWrap (SecTensWrap)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .d_i        (d),
        .loadn_i    (loadn),
        .pgt_1hz_i  (pgt),
        .enn_i      (enn),
        .sec_ones_o (sec_ones),
        .sec_tens_o (sec_tens),
        .min_ones_o (min_ones),
        .min_tens_o (min_tens),
        .zero_o     (zero),
        .done_o     (done)
    );

    // One second off mm:ss: plain decimal step unless seconds are :00, which borrows a
    // minute (decimal on mm) and reloads seconds to SecTensWrap9. Holds at 00:00.
    function automatic int dec_model(input int n);
        if (n == 0) return 0;
        if (n % 100 != 0) return n - 1;
        return n - 100 + int'(SecTensWrap) * 10 + 9;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".min_tens"}, {28'd0, min_tens}, model_n / 1000);
        check({tag, ".min_ones"}, {28'd0, min_ones}, (model_n / 100) % 10);
        check({tag, ".sec_tens"}, {28'd0, sec_tens}, (model_n / 10) % 10);
        check({tag, ".sec_ones"}, {28'd0, sec_ones}, model_n % 10);
        check({tag, ".zero"}, {31'd0, zero}, (model_n == 0) ? 1 : 0);
        check({tag, ".done_cnt"}, done_cnt, exp_done);
    endtask

    task automatic press_key(input logic [3:0] kd, input int hold);
        @(negedge clk);
        d     = kd;
        loadn = 1'b0;
        repeat (hold) @(negedge clk);
        loadn = 1'b1;
        repeat (6) @(negedge clk);
        if (enn && kd <= 4'd9) model_n = (model_n * 10 + int'(kd)) % 10000;
    endtask

    task automatic do_tick();
        @(negedge clk);
        pgt = 1'b1;
        repeat (6) @(negedge clk);
        pgt = 1'b0;
        repeat (6) @(negedge clk);
        if (!enn) begin
            if (model_n != 0 && dec_model(model_n) == 0) exp_done++;
            model_n = dec_model(model_n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        pgt     = 1'b0;
        loadn   = 1'b1;
        model_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        d     = 4'd0;
        loadn = 1'b1;
        pgt   = 1'b0;
        enn   = 1'b1;
        repeat (3) @(negedge clk);
        check_state("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Entry
        press_key(4'd1, 2);
        press_key(4'd3, 3);
        press_key(4'd0, 1);
        check_state("entry_0130");
        press_key(4'd5, 20);
        check_state("held_key");
        press_key(4'hB, 3);
        check_state("invalid_key");

        // Load 01:00, then check tick latency
        do_reset();
        press_key(4'd1, 2);
        press_key(4'd0, 2);
        press_key(4'd0, 2);
        check_state("load_0100");
        enn = 1'b0;
        @(negedge clk);
        pgt = 1'b1;
        repeat (SyncStages) @(posedge clk);
        #1 check_state("latency_before");
        @(posedge clk);
        #1 model_n = dec_model(model_n);
        check_state("latency_at");
        repeat (4) @(negedge clk);
        pgt = 1'b0;
        repeat (6) @(negedge clk);
        check_state("tick_0059");
        for (int i = 0; i < 59; i++) do_tick();
        check_state("count_to_zero");
        for (int i = 0; i < 3; i++) do_tick();
        check_state("hold_at_zero");

        // Borrow chain
        enn = 1'b1;
        press_key(4'd1, 2);
        press_key(4'd0, 2);
        press_key(4'd0, 2);
        press_key(4'd0, 2);
        enn = 1'b0;
        do_tick();
        check_state("borrow_1000");
        enn = 1'b1;
        do_reset();
        press_key(4'd9, 2);
        press_key(4'd0, 2);
        enn = 1'b0;
        do_tick();
        check_state("borrow_0090");

        // Mode holds
        press_key(4'd7, 3);
        check_state("key_while_counting");
        enn = 1'b1;
        do_tick();
        check_state("tick_while_idle");

        // enn falls in the clock that samples the key event: key must be ignored
        @(negedge clk);
        d     = 4'd4;
        loadn = 1'b0;
        repeat (SyncStages) @(negedge clk);
        enn = 1'b0;
        repeat (3) @(negedge clk);
        loadn = 1'b1;
        repeat (6) @(negedge clk);
        check_state("mode_race");

        // Asynchronous reset mid-tick
        @(negedge clk);
        pgt = 1'b1;
        repeat (SyncStages) @(negedge clk);
        #2 rst_n = 1'b0;
        pgt = 1'b0;
        model_n = 0;
        #1 check_state("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Count started at 00:00
        do_tick();
        do_tick();
        check_state("start_at_zero");

        // Randomised entry and count against the model
        for (int t = 0; t < 6; t++) begin
            enn = 1'b1;
            do_reset();
            for (int k = 0; k < 4; k++) begin
                press_key(4'($urandom_range(0, 15)), int'($urandom_range(1, 4)));
            end
            check_state($sformatf("rand%0d_entry", t));
            enn = 1'b0;
            for (int k = 0, n = int'($urandom_range(1, 25)); k < n; k++) do_tick();
            check_state($sformatf("rand%0d_count", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time limit so a stuck run still reports
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, expected finish before limit");
        $fatal(1, "timeout");
    end

endmodule
